// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, valid/ready on both sides.
// Build option AES_DEC_KEY_LATCH_EN: latch the expanded key at acceptance instead of reading it live.
module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  cipher_text,
    input  logic [1407:0] expanded_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  plain_text,
    output logic          busy
);
    // state | meaning
    // IDLE  | waiting for a ciphertext, in_ready high
    // ROUND | one inverse round per clock, rnd_q counts 9..0
    // DONE  | plain_text held until the consumer accepts it
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

    localparam logic [3:0] RND_FIRST = 4'(NR - 1);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of column c is byte 4c+r; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   m2, m4, m8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[8*(4*c+r) +: 8];
                m2    = xt(a[r]);
                m4    = xt(m2);
                m8    = xt(m4);
                m9[r] = m8 ^ a[r];
                mb[r] = m8 ^ m2 ^ a[r];
                md[r] = m8 ^ m4 ^ a[r];
                me[r] = m8 ^ m4 ^ m2;
            end
            o[8*(4*c+0) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[8*(4*c+1) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[8*(4*c+2) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[8*(4*c+3) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   state_q, state_d;
    logic [127:0]   plain_q, plain_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           accept;
    logic [1407:0]  key_src;
    logic [10:0]    rk_idx;
    logic [127:0]   rk;
    logic [127:0]   sub_rows;

    assign in_ready   = (fsm_q == S_IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign busy       = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
    assign out_valid  = out_valid_q;
    assign plain_text = plain_q;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [1407:0] key_q;

    // Key storage needs no reset; it is always written at acceptance before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q <= expanded_key;
        end
    end

    assign key_src = key_q;
`else
    assign key_src = expanded_key;
`endif

    assign rk_idx   = {rnd_q, 7'd0};
    assign rk       = key_src[rk_idx +: 128];
    assign sub_rows = inv_sub_bytes(inv_shift_rows(state_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            plain_q     <= '0;
            out_valid_q <= 1'b0;
            rnd_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            plain_q     <= plain_d;
            out_valid_q <= out_valid_d;
            rnd_q       <= rnd_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        plain_d     = plain_q;
        out_valid_d = out_valid_q;
        rnd_d       = rnd_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = cipher_text ^ expanded_key[1407:1280];
                    rnd_d   = RND_FIRST;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_q == 4'd0) begin
                    plain_d     = sub_rows ^ rk;
                    out_valid_d = 1'b1;
                    fsm_d       = S_DONE;
                end else begin
                    state_d = inv_mix_columns(sub_rows ^ rk);
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: known-answer vectors, handshake timing, abort and key-latch cases.
module tb_aes_decrypt_iter;
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  cipher_text;
    logic [1407:0] expanded_key;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  plain_text;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] CB_KEY  = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] CB_CT   = 128'h4b286e22c5d2113d01227cc2cdf88f39;
    localparam logic [127:0] CB_PT   = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
    localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cipher_text  (cipher_text),
        .expanded_key (expanded_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .plain_text   (plain_text),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [7:0]    ek [176];
        logic [7:0]    t  [4];
        logic [7:0]    rcon, t0;
        logic [1407:0] bus;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) ek[i] = key[8*i +: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = ek[i-4+j];
            if (i % 16 == 0) begin
                t0   = t[0];
                t[0] = sbox(t[1]) ^ rcon;
                t[1] = sbox(t[2]);
                t[2] = sbox(t[3]);
                t[3] = sbox(t0);
                rcon = gmul(rcon, 8'h02);
            end
            for (int j = 0; j < 4; j++) ek[i+j] = ek[i-16+j] ^ t[j];
        end
        bus = '0;
        for (int i = 0; i < 176; i++) bus[8*i +: 8] = ek[i];
        return bus;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [127:0] ct, input logic [1407:0] ek);
        cipher_text  = ct;
        expanded_key = ek;
        in_valid     = 1'b1;
        check("in_ready_before_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    logic [1407:0] ek_cb, ek_fips;
    int            lat;
    int            extra;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        cipher_text  = '0;
        expanded_key = '0;
        ek_cb   = key_expand(CB_KEY);
        ek_fips = key_expand(FIPS_KEY);

        // Reset state, and rst together with in_valid accepts nothing.
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_plain", plain_text, '0);
        check("rst_busy", busy, 1'b0);
        cipher_text  = CB_CT;
        expanded_key = ek_cb;
        in_valid     = 1'b1;
        tick();
        check("rst_wins_busy", busy, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Codebase vector with latency.
        request(CB_CT, ek_cb);
        wait_valid(0, lat);
        check("cb_latency", lat, 10);
        check("cb_plain", plain_text, CB_PT);
        tick();
        check("cb_out_valid_drop", out_valid, 1'b0);
        check("cb_in_ready_back", in_ready, 1'b1);

        // FIPS-197 C.1 vector.
        request(FIPS_CT, ek_fips);
        wait_valid(0, lat);
        check("fips_latency", lat, 10);
        check("fips_plain", plain_text, FIPS_PT);
        tick();

        // Back-pressure: five stalled cycles, completion on the sixth.
        out_ready = 1'b0;
        request(CB_CT, ek_cb);
        wait_valid(0, lat);
        check("bp_latency", lat, 10);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_plain_held", plain_text, CB_PT);
            check("bp_in_ready_low", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_valid_6th", out_valid, 1'b1);
        check("bp_in_ready_6th", in_ready, 1'b0);
        tick();
        check("bp_valid_7th", out_valid, 1'b0);
        check("bp_in_ready_7th", in_ready, 1'b1);

        // in_valid pulse at T3 is ignored.
        request(CB_CT, ek_cb);
        tick();
        tick();
        cipher_text = FIPS_CT;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        cipher_text = CB_CT;
        wait_valid(3, lat);
        check("pulse_latency", lat, 10);
        check("pulse_plain", plain_text, CB_PT);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) extra++;
        end
        check("pulse_no_second_valid", extra, 0);
        check("pulse_idle_busy", busy, 1'b0);

        // Reset pulse at T5 aborts the block.
        request(CB_CT, ek_cb);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_plain", plain_text, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid) extra++;
        end
        check("abort_no_valid", extra, 0);
        request(CB_CT, ek_cb);
        wait_valid(0, lat);
        check("abort_fresh_latency", lat, 10);
        check("abort_fresh_plain", plain_text, CB_PT);
        tick();

        // Key source cleared from T1 onward.
        request(CB_CT, ek_cb);
        expanded_key = '0;
        wait_valid(0, lat);
        check("keylatch_latency", lat, 10);
`ifdef AES_DEC_KEY_LATCH_EN
        check("keylatch_plain", plain_text, CB_PT);
`else
        check("keylive_plain_differs", plain_text != CB_PT, 1'b1);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 inverse cipher. Sits downstream of the cipher path.
- Takes a 128-bit ciphertext and the 1408-bit expanded key bus produced by the existing key expansion.
- Executes one inverse round per clock and returns the plaintext through a valid/ready output handshake.
- Used to close the loop on encrypt results in the same FPGA build.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext/key presented
- in_ready  output  1  block can accept; high only in IDLE and rst low
- cipher_text  input  128  ciphertext; state byte i = bits [8i+7:8i]
- expanded_key  input  1408  round key r = bits [128r+127:128r]; r=0 is the cipher key
- out_valid  output  1  plain_text valid
- out_ready  input  1  consumer accepts plain_text
- plain_text  output  128  decrypted block, same byte order as cipher_text
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset values: state IDLE, out_valid 0, plain_text 0, round counter 0, busy 0. in_ready is 0 while rst is high.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - Accept when in_valid && in_ready (edge T0).
  - At T0, state_reg <= cipher_text ^ rk10 and rnd <= 9; go to ROUND.
- ROUND, rnd 9..1:
  - state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[rnd])).
  - rnd decrements each cycle.
- ROUND, rnd = 0 (final round):
  - plain_text <= InvSubBytes(InvShiftRows(state_reg)) ^ rk0.
  - out_valid <= 1; go to DONE.
- Latency: acceptance edge T0, final-round edge T10; out_valid is high in the cycle after T10, i.e. 10 clocks after acceptance.
- DONE:
  - out_valid and plain_text are held stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, go to IDLE. in_ready rises the following cycle; there is no same-cycle restart.
- in_valid while not IDLE is ignored; no queuing and no error.
- out_ready is ignored outside DONE.
- InvShiftRows: row r rotates right by r. Row r of column c is state byte 4c+r.
- InvMixColumns: GF(2^8) multiply by 0e/0b/0d/09, reduction polynomial 0x11b.
- Inverse S-box: one 256-entry constant table, instanced 16 times; combinational per round.
- rst asserted mid-operation: abort immediately. Next cycle is IDLE with out_valid 0 and plain_text 0; no partial result is ever flagged valid.
- rst and in_valid together: reset wins; nothing is accepted.

Optional Feature:
- Macro: AES_DEC_KEY_LATCH_EN.
- Defined: a 1408-bit key register captures expanded_key at T0. Rounds read the latched copy, so the source may change from T0+1 onward.
- Undefined: no key register. Rounds read expanded_key directly, which must be stable from T0 until out_valid. Saves 1408 flops.
- Latency and handshake are identical in both builds.

Test Plan:
- Codebase vector: expanded_key = key-expansion output for key 128'h100F0E0D0C0B0A090807060504030201, cipher_text = 128'h4b286e22c5d2113d01227cc2cdf88f39 -> plain_text = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1, out_valid exactly 10 clocks after acceptance.
- FIPS-197 C.1 vector in LSB-byte order: key 128'h0f0e0d0c0b0a09080706050403020100 (expansion from bench model), cipher_text 128'h5ac5b47080b7cdd830047b6ad8e0c469 -> plain_text 128'hffeeddccbbaa99887766554433221100.
- Back-pressure: out_ready low for 5 cycles after out_valid -> out_valid and plain_text stable throughout. Completion on the 6th cycle; in_ready high on the 7th.
- in_valid pulsed with a different ciphertext at T3 -> ignored; the first result is unchanged and no second out_valid appears.
- rst pulsed for one cycle at T5 -> out_valid stays 0 and plain_text reads 0. A fresh request afterward yields the correct codebase vector result.
- Key-latch check, AES_DEC_KEY_LATCH_EN defined: expanded_key driven to all zeros from T1 -> result still equals the codebase vector plaintext. With the macro undefined, the same stimulus yields a result different from the vector.
